// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_RING
  } state_t;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Width able to hold 0..ticks, never narrower than one bit.
  function automatic int unsigned ring_cnt_width(input int unsigned ticks);
    int unsigned w;
    w = $clog2(ticks + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_selfsubber.sv
// One BCD digit: loadable down-counter that reloads to its limit on borrow.
module selfsubber (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic [3:0] limit_i,
  output logic [3:0] value_o,
  output logic       borrow_o
);

  logic [3:0] value_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (en_i) begin
      value_q <= (value_q == '0) ? limit_i : value_q - 4'd1;
    end
  end

  assign value_o  = value_q;
  assign borrow_o = en_i & (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with run/pause control and a timed expiry ring.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned RING_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned CW = ring_cnt_width(RING_TICKS);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_TICKS - 1);

  state_t        state_q;
  logic [CW-1:0] ring_cnt_q;
  logic          done_q;

  logic [3:0] su_q, st_q, mu_q, mt_q;
  logic       b_su, b_st, b_mu, b_mt;
  logic       load_acc, dec, count_zero, at_one;

  assign load_acc   = load & (state_q != S_RUN);
  assign dec        = (state_q == S_RUN) & tick & ~pause;
  assign count_zero = (mt_q == '0) & (mu_q == '0) & (st_q == '0) & (su_q == '0);
  assign at_one     = (mt_q == '0) & (mu_q == '0) & (st_q == '0) & (su_q == 4'd1);

  // Borrow ripples combinationally from seconds units up to minutes tens.
  selfsubber u_sec_units (
    .clk_i(clk), .rst_ni(reset), .en_i(dec), .load_i(load_acc),
    .load_val_i(clamp_digit(sec_in[3:0], UNITS_MAX)), .limit_i(UNITS_MAX),
    .value_o(su_q), .borrow_o(b_su)
  );

  selfsubber u_sec_tens (
    .clk_i(clk), .rst_ni(reset), .en_i(b_su), .load_i(load_acc),
    .load_val_i(clamp_digit(sec_in[7:4], TENS_MAX)), .limit_i(TENS_MAX),
    .value_o(st_q), .borrow_o(b_st)
  );

  selfsubber u_min_units (
    .clk_i(clk), .rst_ni(reset), .en_i(b_st), .load_i(load_acc),
    .load_val_i(clamp_digit(min_in[3:0], UNITS_MAX)), .limit_i(UNITS_MAX),
    .value_o(mu_q), .borrow_o(b_mu)
  );

  selfsubber u_min_tens (
    .clk_i(clk), .rst_ni(reset), .en_i(b_mu), .load_i(load_acc),
    .load_val_i(clamp_digit(min_in[7:4], UNITS_MAX)), .limit_i(UNITS_MAX),
    .value_o(mt_q), .borrow_o(b_mt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ring_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (!load && start && !count_zero) state_q <= S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_q <= S_PAUSE;
          end else if (dec && at_one) begin
            state_q    <= S_RING;
            ring_cnt_q <= '0;
            done_q     <= 1'b1;
          end
        end
        S_RING: begin
          if (load || start) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) begin
              state_q    <= S_IDLE;
              ring_cnt_q <= '0;
            end else begin
              ring_cnt_q <= ring_cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign min_out = {mt_q, mu_q};
  assign sec_out = {st_q, su_q};
  assign running = (state_q == S_RUN);
  assign expired = (state_q == S_RING);
  assign done    = done_q;

  logic unused_borrow;
  assign unused_borrow = b_mt;

endmodule
